// File: rtl/fetch_defs_pkg.sv
// ============================================================================
// fetch_defs : shared constants and opcode encodings for the fetch stage
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_defs;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  localparam int QUEUE_DEPTH = 2;
  localparam int COUNT_WIDTH = 2;

  // Brainfuck program alphabet; OP_END terminates the program image.
  typedef enum logic [7:0] {
    OP_END        = 8'h00,
    OP_INC        = 8'h2B,
    OP_IN         = 8'h2C,
    OP_DEC        = 8'h2D,
    OP_OUT        = 8'h2E,
    OP_LEFT       = 8'h3C,
    OP_RIGHT      = 8'h3E,
    OP_LOOP_OPEN  = 8'h5B,
    OP_LOOP_CLOSE = 8'h5D
  } bf_op_e;

  function automatic logic is_end_word(input logic [7:0] word);
    return word == OP_END;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ============================================================================
// instr_fetch_if : ROM read port, decoder handshake and redirect signals
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if #(
  parameter int DATA_WIDTH = fetch_defs::DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = fetch_defs::DEFAULT_ADDR_WIDTH
);

  logic                  rom_ren;
  logic [ADDR_WIDTH-1:0] rom_raddr;
  logic [DATA_WIDTH-1:0] rom_rdata;

  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;

  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  halted;

  // Fetch stage side
  modport master (
    output rom_ren, rom_raddr,
    input  rom_rdata,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready,
    input  jump_en, jump_addr,
    output halted
  );

  // ROM / decoder / loop-logic side
  modport slave (
    input  rom_ren, rom_raddr,
    output rom_rdata,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready,
    output jump_en, jump_addr,
    input  halted
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue2.sv
// ============================================================================
// fetch_queue2 : two-entry {word, pc} FIFO, head held in entry 0
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue2
  import fetch_defs::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_word,
  input  logic [ADDR_WIDTH-1:0]  push_pc,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  head_word,
  output logic [ADDR_WIDTH-1:0]  head_pc,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [DATA_WIDTH-1:0] word0, word1;
  logic [ADDR_WIDTH-1:0] pc0, pc1;
  logic                  pop_ok;
  logic                  push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != COUNT_WIDTH'(QUEUE_DEPTH)) || pop_ok);

  assign head_word = word0;
  assign head_pc   = pc0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word0 <= '0;
      word1 <= '0;
      pc0   <= '0;
      pc1   <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == '0) begin
            word0 <= push_word;
            pc0   <= push_pc;
          end else begin
            word1 <= push_word;
            pc1   <= push_pc;
          end
          count <= count + COUNT_WIDTH'(1);
        end
        2'b01: begin
          word0 <= word1;
          pc0   <= pc1;
          count <= count - COUNT_WIDTH'(1);
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor.
          if (count == COUNT_WIDTH'(1)) begin
            word0 <= push_word;
            pc0   <= push_pc;
          end else begin
            word0 <= word1;
            pc0   <= pc1;
            word1 <= push_word;
            pc1   <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : PC owner, ROM read issue, 2-deep buffering and jump redirect
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import fetch_defs::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  logic [ADDR_WIDTH-1:0]  pc;
  logic                   inflight;
  logic [ADDR_WIDTH-1:0]  inflight_addr;
  logic                   stop;

  logic [DATA_WIDTH-1:0]  head_word;
  logic [ADDR_WIDTH-1:0]  head_pc;
  logic [COUNT_WIDTH-1:0] count;

  logic                   head_present;
  logic                   head_is_end;
  logic                   pop;
  logic                   jump;
  logic                   ret_end;
  logic [2:0]             occupancy;
  logic                   seq_issue;
  logic                   issue;
  logic [ADDR_WIDTH-1:0]  fetch_addr;

  assign head_present = (count != '0);
  assign head_is_end  = (head_word == DATA_WIDTH'(OP_END));

  assign bus.instr_valid = head_present && !head_is_end;
  assign bus.halted      = head_present && head_is_end;
  assign bus.instr_data  = head_word;
  assign bus.instr_pc    = head_pc;

  assign pop     = bus.instr_valid && bus.instr_ready;
  assign jump    = bus.jump_en && !bus.halted;
  assign ret_end = inflight && (bus.rom_rdata == DATA_WIDTH'(OP_END));

  // Words buffered or on their way after this cycle; a pop implies count >= 1.
  assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);
  assign seq_issue = (occupancy < 3'd2) && !stop && !bus.halted && !ret_end;

  // Reset is asynchronous, so the read port is held quiet while it is asserted.
  assign issue      = !rst && (jump || seq_issue);
  assign fetch_addr = jump ? bus.jump_addr : pc;

  assign bus.rom_ren   = issue;
  assign bus.rom_raddr = fetch_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      stop          <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_addr <= fetch_addr;
        pc            <= fetch_addr + ADDR_WIDTH'(1);
      end
      if (jump) begin
        stop <= 1'b0;
      end else if (ret_end) begin
        stop <= 1'b1;
      end
    end
  end

  // A redirect flushes the queue and drops the word returning this cycle.
  fetch_queue2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump),
    .push      (inflight && !jump),
    .push_word (bus.rom_rdata),
    .push_pc   (inflight_addr),
    .pop       (pop),
    .head_word (head_word),
    .head_pc   (head_pc),
    .count     (count)
  );

endmodule

`default_nettype wire
